// File: rtl/cascaded_counter_pkg.sv
// Shared types and helpers for the cascaded digit counter chain.
// Holds the FSM state encoding, digit saturation and parameter legality check.
package cascaded_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 8;
  localparam int MIN_MOD    = 2;

  // Clamp a loaded digit into the legal range 0..modulus-1.
  function automatic int unsigned sat_digit(input int unsigned v, input int unsigned modulus);
    return (v >= modulus) ? modulus - 1 : v;
  endfunction

  function automatic bit params_ok(input int stages, input int w, input int modulus);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES) && (w >= 1) && (w <= 31) &&
           (modulus >= MIN_MOD) && (longint'(modulus) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/counter_stage.sv
// One modulo-STAGE_MOD digit of the chain; increments when carry_in is high.
// Latency: digit updates at the clock edge that samples carry_in; tc is combinational.
// Backpressure: none; clr > load > carry_in.
module counter_stage
  import cascaded_counter_pkg::*;
#(
  parameter int STAGE_W   = 4,
  parameter int STAGE_MOD = 16
) (
  input  logic               CK,
  input  logic               RSTN,
  input  logic               clr,
  input  logic               load,
  input  logic [STAGE_W-1:0] load_digit,
  input  logic               carry_in,
  output logic [STAGE_W-1:0] digit,
  output logic               tc
);

  localparam logic [STAGE_W-1:0] MAXD = STAGE_W'(STAGE_MOD - 1);

  assign tc = carry_in && (digit == MAXD);

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= STAGE_W'(sat_digit(32'(load_digit), STAGE_MOD));
    end else if (carry_in) begin
      digit <= tc ? '0 : digit + STAGE_W'(1);
    end
  end

endmodule

// File: rtl/cascaded_counter_chain.sv
// Chain of STAGES modulo-STAGE_MOD digits with run-control FSM, load, compare and wrap/overflow flags.
// Latency: EN sampled at edge n updates CNT at edge n; MATCH/WRAP/OVF/BUSY/DONE aligned with CNT.
// Backpressure: none; EN gates counting, priority RSTN > CLR > LOAD > START > count.
module cascaded_counter_chain
  import cascaded_counter_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int STAGE_W   = 4,
  parameter int STAGE_MOD = 16
) (
  input  logic                        CK,
  input  logic                        RSTN,
  input  logic                        EN,
  input  logic                        CLR,
  input  logic                        START,
  input  logic                        MODE,
  input  logic                        LOAD,
  input  logic [STAGES*STAGE_W-1:0]   LOAD_VAL,
  input  logic [STAGES*STAGE_W-1:0]   CMP_VAL,
  output logic [STAGES*STAGE_W-1:0]   CNT,
  output logic [STAGES-1:0]           STAGE_TC,
  output logic                        MATCH,
  output logic                        WRAP,
  output logic                        OVF,
  output logic                        BUSY,
  output logic                        DONE
);

  localparam int                 N    = STAGES * STAGE_W;
  localparam logic [STAGE_W-1:0] MAXD = STAGE_W'(STAGE_MOD - 1);

  if (!params_ok(STAGES, STAGE_W, STAGE_MOD)) begin : g_bad_params
    $error("cascaded_counter_chain: illegal STAGES/STAGE_W/STAGE_MOD combination");
  end

  state_t             state;
  logic               mode_l;
  logic [STAGES-1:0]  carry;
  logic [STAGES-1:0]  tc;
  logic [N-1:0]       next_cnt;
  logic               chain_term;
  logic               load_eff;
  logic               restart;
  logic               hold_max;
  logic               wrap_evt;
  logic               stg_clr;
  logic               stg_load;
  logic               match_n;

  assign chain_term = tc[STAGES-1];
  assign load_eff   = LOAD && !CLR;
  assign restart    = START && !CLR && !LOAD && (state == ST_DONE);
  // One-shot terminal: reload all-max so the chain holds instead of wrapping.
  assign hold_max   = chain_term && mode_l && !CLR && !LOAD;
  assign wrap_evt   = chain_term && !mode_l && !CLR && !LOAD;
  assign stg_clr    = CLR || restart;
  assign stg_load   = load_eff || hold_max;
  assign STAGE_TC   = tc;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [STAGE_W-1:0] dig;
    logic [STAGE_W-1:0] ldd;
    logic [STAGE_W-1:0] nd;

    if (k == 0) begin : g_c0
      assign carry[k] = EN && (state == ST_RUN);
    end else begin : g_cn
      assign carry[k] = tc[k-1];
    end

    assign ldd = LOAD ? LOAD_VAL[k*STAGE_W +: STAGE_W] : MAXD;

    counter_stage #(
      .STAGE_W   (STAGE_W),
      .STAGE_MOD (STAGE_MOD)
    ) u_stage (
      .CK         (CK),
      .RSTN       (RSTN),
      .clr        (stg_clr),
      .load       (stg_load),
      .load_digit (ldd),
      .carry_in   (carry[k]),
      .digit      (dig),
      .tc         (tc[k])
    );

    // Next-state view of this digit, used only for the compare pulse.
    always_comb begin
      nd = dig;
      if (stg_clr) begin
        nd = '0;
      end else if (stg_load) begin
        nd = STAGE_W'(sat_digit(32'(ldd), STAGE_MOD));
      end else if (carry[k]) begin
        nd = tc[k] ? '0 : dig + STAGE_W'(1);
      end
    end

    assign CNT[k*STAGE_W +: STAGE_W]      = dig;
    assign next_cnt[k*STAGE_W +: STAGE_W] = nd;
  end

  assign match_n = (next_cnt == CMP_VAL) && ((next_cnt != CNT) || load_eff);

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      MATCH <= 1'b0;
      WRAP  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      MATCH <= match_n;
      WRAP  <= wrap_evt;
      if (CLR) begin
        OVF <= 1'b0;
      end else if (wrap_evt) begin
        OVF <= 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state  <= ST_IDLE;
      mode_l <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else if (CLR) begin
      state <= ST_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (!LOAD) begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state  <= ST_RUN;
            mode_l <= MODE;
            BUSY   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (chain_term && mode_l) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (START) begin
            state <= ST_RUN;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
